// File: rtl/lcd_cfah_bus_ctrl_if.sv
// Bus bundle between the LCD command sequencer (master) and the HD44780 bus controller (slave).
interface lcd_cfah_bus_ctrl_if #(parameter int DW = 8);
  logic          start, rs, rw, single_nib;
  logic [7:0]    wdata;
  logic [DW-1:0] lcd_data;
  logic [DW-1:0] lcd_wdata;
  logic          lcd_rs, lcd_rw, lcd_en, bidir_sel;
  logic [7:0]    rdata;
  logic          ready, done, timeout;

  modport slave (
    input  start, rs, rw, single_nib, wdata, lcd_data,
    output lcd_wdata, lcd_rs, lcd_rw, lcd_en, bidir_sel, rdata, ready, done, timeout
  );
  modport master (
    output start, rs, rw, single_nib, wdata, lcd_data,
    input  lcd_wdata, lcd_rs, lcd_rw, lcd_en, bidir_sel, rdata, ready, done, timeout
  );
endinterface

// File: rtl/lcd_cfah_bus_ctrl.sv
// HD44780-style bus transfer engine: one register access per start, 8- or 4-bit bus,
// ns-derived setup/pulse/hold/cycle timing and optional busy-flag polling after writes.
module lcd_cfah_bus_ctrl #(
  parameter int G_CLK_PERIOD_NS      = 20,
  parameter int G_DATA_WIDTH         = 8,
  parameter int G_T_AS_NS            = 40,
  parameter int G_PW_EN_NS           = 230,
  parameter int G_T_H_NS             = 10,
  parameter int G_T_CYC_NS           = 500,
  parameter bit G_BIDIR_SEL_POLARITY = 1'b1,
  parameter bit G_BUSY_POLL          = 1'b0,
  parameter int G_POLL_MAX           = 1000
) (
  input logic clk,
  input logic rst_n,
  lcd_cfah_bus_ctrl_if.slave bus
);
  localparam int DW = G_DATA_WIDTH;

  function automatic int cdiv(int ns);
    return (ns + G_CLK_PERIOD_NS - 1) / G_CLK_PERIOD_NS;
  endfunction
  function automatic int max1(int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int C_AS  = max1(cdiv(G_T_AS_NS));
  localparam int C_PW  = max1(cdiv(G_PW_EN_NS));
  localparam int C_H   = max1(cdiv(G_T_H_NS));
  localparam int C_CYC = cdiv(G_T_CYC_NS);
  localparam int C_GAP = (C_CYC > C_AS + C_PW + C_H) ? C_CYC - C_AS - C_PW - C_H : 0;
  localparam int PW    = $clog2(G_POLL_MAX + 1);

  if (DW != 8 && DW != 4) begin : g_bad_width
    $error("lcd_cfah_bus_ctrl: G_DATA_WIDTH must be 8 or 4");
  end

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, GAP} state_t;

  state_t        state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic          ph, ph_n, polling, poll_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic          rs_q, rs_n, rw_q, rw_n, single_q, single_n;
  logic [7:0]    wdata_q, wdata_n, rd_buf, rdata_n;
  logic          done_n, tmo_n, phase_end, last_phase, busy;
  logic          rs_e, rw_e, drive;
  logic [DW-1:0] nib;

  assign last_phase = (DW == 8) || single_q || ph;
  assign busy       = rd_buf[7];

  always_comb begin
    state_n = state;  cnt_n = cnt + 16'd1;  ph_n = ph;  poll_n = polling;  pcnt_n = pcnt;
    rs_n = rs_q;  rw_n = rw_q;  single_n = single_q;  wdata_n = wdata_q;
    rdata_n = bus.rdata;  done_n = 1'b0;  tmo_n = 1'b0;  phase_end = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.start) begin
          state_n = SETUP;  ph_n = 1'b0;  poll_n = 1'b0;  pcnt_n = '0;
          rs_n = bus.rs;  rw_n = bus.rw;  wdata_n = bus.wdata;
          single_n = bus.single_nib && (DW == 4);
        end
      end
      SETUP: if (cnt == 16'(C_AS - 1)) begin state_n = EN_HI; cnt_n = '0; end
      EN_HI: if (cnt == 16'(C_PW - 1)) begin state_n = HOLD;  cnt_n = '0; end
      HOLD:  if (cnt == 16'(C_H - 1)) begin
               cnt_n = '0;
               if (C_GAP > 0) state_n = GAP;
               else           phase_end = 1'b1;
             end
      GAP:   if (cnt == 16'(C_GAP - 1)) begin cnt_n = '0; phase_end = 1'b1; end
      default: state_n = IDLE;
    endcase

    // Phase boundary: next nibble, start/continue polling, or finish.
    if (phase_end) begin
      state_n = SETUP;
      if (!last_phase) ph_n = 1'b1;
      else begin
        ph_n = 1'b0;
        if (!polling && !rw_q && G_BUSY_POLL && !single_q) begin
          poll_n = 1'b1;  pcnt_n = PW'(1);
        end else if (polling && busy && pcnt != PW'(G_POLL_MAX)) begin
          pcnt_n = pcnt + PW'(1);
        end else begin
          state_n = IDLE;  done_n = 1'b1;  tmo_n = polling && busy;
          if (!polling && rw_q) rdata_n = rd_buf;
        end
      end
    end

    rs_e  = poll_n ? 1'b0 : rs_n;
    rw_e  = poll_n ? 1'b1 : rw_n;
    drive = (state_n inside {SETUP, EN_HI, HOLD}) && !rw_e;
    nib   = (DW == 8) ? DW'(wdata_n) : DW'(ph_n ? wdata_n[3:0] : wdata_n[7:4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;  cnt <= '0;  ph <= 1'b0;  polling <= 1'b0;  pcnt <= '0;
      rs_q <= 1'b0;  rw_q <= 1'b0;  single_q <= 1'b0;  wdata_q <= '0;  rd_buf <= '0;
      bus.lcd_en <= 1'b0;  bus.lcd_rs <= 1'b0;  bus.lcd_rw <= 1'b0;  bus.lcd_wdata <= '0;
      bus.bidir_sel <= !G_BIDIR_SEL_POLARITY;  bus.rdata <= '0;
      bus.ready <= 1'b1;  bus.done <= 1'b0;  bus.timeout <= 1'b0;
    end else begin
      state <= state_n;  cnt <= cnt_n;  ph <= ph_n;  polling <= poll_n;  pcnt <= pcnt_n;
      rs_q <= rs_n;  rw_q <= rw_n;  single_q <= single_n;  wdata_q <= wdata_n;
      // Seed with the old byte so a single-nibble read keeps the low nibble.
      if (state == IDLE && bus.start) rd_buf <= bus.rdata;
      else if (state == EN_HI && cnt == 16'(C_PW - 1) && (polling || rw_q)) begin
        if (DW == 8)  rd_buf      <= 8'(bus.lcd_data);
        else if (!ph) rd_buf[7:4] <= 4'(bus.lcd_data);
        else          rd_buf[3:0] <= 4'(bus.lcd_data);
      end
      bus.lcd_en    <= (state_n == EN_HI);
      bus.lcd_rs    <= rs_e;
      bus.lcd_rw    <= rw_e;
      bus.lcd_wdata <= drive ? nib : '0;
      bus.bidir_sel <= drive ? G_BIDIR_SEL_POLARITY : !G_BIDIR_SEL_POLARITY;
      bus.rdata     <= rdata_n;
      bus.ready     <= (state_n == IDLE);
      bus.done      <= done_n;
      bus.timeout   <= tmo_n;
    end
  end
endmodule
